// File: rtl/stream_mux_rr_pkg.sv
// Shared helpers for the round-robin stream multiplexer.
// Only a clog2 that never returns zero lives here.
package stream_mux_rr_pkg;

  function automatic int clog2_safe(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a forced-select override.
// Owns the rotating priority pointer and the wrap-around priority search.
module rr_arbiter
  import stream_mux_rr_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = clog2_safe(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  input  logic             force_en,
  input  logic [SEL_W-1:0] force_sel,
  output logic [N-1:0]     gnt_oh,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     cand;
  logic [SEL_W:0]   pos;

  // An out-of-range force_sel matches no channel, so nothing is granted.
  always_comb begin
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand[i] = req[i] & (~force_en | (force_sel == SEL_W'(i)));
    end
  end

  // NOTE: every output of this block gets a default before the loop so no
  // path leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr_q} + (SEL_W + 1)'(k);
      if (pos >= (SEL_W + 1)'(N)) pos = pos - (SEL_W + 1)'(N);
      if (!gnt_vld && cand[pos[SEL_W-1:0]]) begin
        gnt_vld                = 1'b1;
        gnt_idx                = pos[SEL_W-1:0];
        gnt_oh[pos[SEL_W-1:0]] = 1'b1;
      end
    end
  end

  assign ptr_d = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + 1'b1;

  // NOTE: state is written with non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance && gnt_vld && !force_en) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with round-robin arbitration, a forced
// channel select and a single registered output stage.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEL_W = clog2_safe(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     up_valid,
  input  logic [N*W-1:0]   up_data,
  output logic [N-1:0]     up_ready,
  input  logic             force_en,
  input  logic [SEL_W-1:0] force_sel,
  output logic             down_valid,
  output logic [W-1:0]     down_data,
  output logic [SEL_W-1:0] down_id,
  input  logic             down_ready
);

  logic [W-1:0]     up_words [N];
  logic [N-1:0]     gnt_oh;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             load_en;
  logic             down_valid_q;
  logic [W-1:0]     down_data_q;
  logic [SEL_W-1:0] down_id_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      up_words[i] = up_data[i*W +: W];
    end
  end

  // The output register can take a word when empty or drained this cycle.
  assign load_en = ~down_valid_q | down_ready;

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (up_valid),
    .advance   (load_en),
    .force_en  (force_en),
    .force_sel (force_sel),
    .gnt_oh    (gnt_oh),
    .gnt_idx   (gnt_idx),
    .gnt_vld   (gnt_vld)
  );

  // Gated by rst_n so no producer sees a handshake while reset is held.
  assign up_ready = gnt_oh & {N{load_en & rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      down_valid_q <= 1'b0;
      down_data_q  <= '0;
      down_id_q    <= '0;
    end else if (load_en) begin
      down_valid_q <= gnt_vld;
      if (gnt_vld) begin
        down_data_q <= up_words[gnt_idx];
        down_id_q   <= gnt_idx;
      end
    end
  end

  assign down_valid = down_valid_q;
  assign down_data  = down_data_q;
  assign down_id    = down_id_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Table-driven bench for stream_mux_rr: each row gives inputs and the
// expected up_ready; granted words go to a scoreboard checked at the output.
module tb_stream_mux_rr;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     up_valid = '0;
  logic [N*W-1:0]   up_data = '0;
  logic [N-1:0]     up_ready;
  logic             force_en = 1'b0;
  logic [SEL_W-1:0] force_sel = '0;
  logic             down_valid;
  logic [W-1:0]     down_data;
  logic [SEL_W-1:0] down_id;
  logic             down_ready = 1'b0;

  typedef struct {
    logic [N-1:0]     valid;
    logic             fe;
    logic [SEL_W-1:0] fs;
    logic             dr;
    logic [W-1:0]     d2;
    logic [N-1:0]     rdy;
    string            name;
  } vec_t;

  typedef struct {
    logic [SEL_W-1:0] id;
    logic [W-1:0]     data;
  } word_t;

  word_t sb[$];
  vec_t  tbl[$];
  int    checks = 0;
  int    errors = 0;
  logic  exp_valid = 1'b0;

  stream_mux_rr dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_ready   (up_ready),
    .force_en   (force_en),
    .force_sel  (force_sel),
    .down_valid (down_valid),
    .down_data  (down_data),
    .down_id    (down_id),
    .down_ready (down_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic [N-1:0] valid, input logic fe,
                               input logic [SEL_W-1:0] fs, input logic dr,
                               input logic [W-1:0] d2, input logic [N-1:0] rdy,
                               input string name);
    vec_t v;
    v.valid = valid; v.fe = fe; v.fs = fs; v.dr = dr;
    v.d2 = d2; v.rdy = rdy; v.name = name;
    return v;
  endfunction

  function automatic word_t mkword(input logic [N-1:0] oh, input logic [W-1:0] d2);
    word_t w;
    w.id = '0;
    w.data = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) begin
        w.id   = SEL_W'(i);
        w.data = (i == 2) ? d2 : W'(8'hA0 + i);
      end
    end
    return w;
  endfunction

  // Drive one row, check at the falling edge, then advance one clock.
  task automatic step(input vec_t v);
    logic nxt;
    up_valid   = v.valid;
    force_en   = v.fe;
    force_sel  = v.fs;
    down_ready = v.dr;
    up_data    = {8'hA3, v.d2, 8'hA1, 8'hA0};
    @(negedge clk);
    check({v.name, " up_ready"}, 32'(up_ready), 32'(v.rdy));
    check({v.name, " down_valid"}, 32'(down_valid), 32'(exp_valid));
    if (exp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s scoreboard: got empty queue expected a word", v.name);
      end else begin
        check({v.name, " down_id"}, 32'(down_id), 32'(sb[0].id));
        check({v.name, " down_data"}, 32'(down_data), 32'(sb[0].data));
        if (v.dr) void'(sb.pop_front());
      end
    end
    nxt = exp_valid;
    if (!exp_valid || v.dr) begin
      nxt = |v.rdy;
      if (|v.rdy) sb.push_back(mkword(v.rdy, v.d2));
    end
    @(posedge clk);
    exp_valid = nxt;
    #1;
  endtask

  initial begin
    up_valid = '1;
    up_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    #12;
    check("in_reset up_ready", 32'(up_ready), 32'h0);
    check("in_reset down_valid", 32'(down_valid), 32'h0);
    check("in_reset down_id", 32'(down_id), 32'h0);
    up_valid = '0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) step(mkv(4'h0, 0, 0, 1, 8'hA2, 4'h0, "idle"));

    // All channels valid: strict rotation 0,1,2,3,0,1.
    tbl.push_back(mkv(4'hF, 0, 0, 1, 8'hA2, 4'b0001, "rr0"));
    tbl.push_back(mkv(4'hF, 0, 0, 1, 8'hA2, 4'b0010, "rr1"));
    tbl.push_back(mkv(4'hF, 0, 0, 1, 8'hA2, 4'b0100, "rr2"));
    tbl.push_back(mkv(4'hF, 0, 0, 1, 8'hA2, 4'b1000, "rr3"));
    tbl.push_back(mkv(4'hF, 0, 0, 1, 8'hA2, 4'b0001, "rr4"));
    tbl.push_back(mkv(4'hF, 0, 0, 1, 8'hA2, 4'b0010, "rr5"));
    // Channels 1 and 3 only; pointer sits at 2 so 3 wins first.
    tbl.push_back(mkv(4'b1010, 0, 0, 1, 8'hA2, 4'b1000, "alt0"));
    tbl.push_back(mkv(4'b1010, 0, 0, 1, 8'hA2, 4'b0010, "alt1"));
    tbl.push_back(mkv(4'b1010, 0, 0, 1, 8'hA2, 4'b1000, "alt2"));
    tbl.push_back(mkv(4'b1010, 0, 0, 1, 8'hA2, 4'b0010, "alt3"));
    // Load id 2 / 5C, stall three cycles, then drain and load with no bubble.
    tbl.push_back(mkv(4'b0100, 0, 0, 1, 8'h5C, 4'b0100, "bp_load"));
    tbl.push_back(mkv(4'hF, 0, 0, 0, 8'h5C, 4'b0000, "bp_hold0"));
    tbl.push_back(mkv(4'hF, 0, 0, 0, 8'h5C, 4'b0000, "bp_hold1"));
    tbl.push_back(mkv(4'hF, 0, 0, 0, 8'h5C, 4'b0000, "bp_hold2"));
    tbl.push_back(mkv(4'hF, 0, 0, 1, 8'h5C, 4'b1000, "bp_release"));
    // Forced channel 2; drop its valid; return to round-robin at ptr 0.
    tbl.push_back(mkv(4'hF, 1, 2, 1, 8'hA2, 4'b0100, "force0"));
    tbl.push_back(mkv(4'hF, 1, 2, 1, 8'hA2, 4'b0100, "force1"));
    tbl.push_back(mkv(4'hF, 1, 2, 1, 8'hA2, 4'b0100, "force2"));
    tbl.push_back(mkv(4'b1011, 1, 2, 1, 8'hA2, 4'b0000, "force_novalid"));
    tbl.push_back(mkv(4'hF, 0, 2, 1, 8'hA2, 4'b0001, "unforce0"));
    tbl.push_back(mkv(4'hF, 0, 2, 1, 8'hA2, 4'b0010, "unforce1"));
    // Channel 0 alone, then channel 3 joins and wins once ptr has moved to 1.
    for (int i = 0; i < 5; i++) tbl.push_back(mkv(4'b0001, 0, 0, 1, 8'hA2, 4'b0001, "solo0"));
    tbl.push_back(mkv(4'b1001, 0, 0, 1, 8'hA2, 4'b1000, "join3"));
    tbl.push_back(mkv(4'b1001, 0, 0, 1, 8'hA2, 4'b0001, "join0"));

    foreach (tbl[i]) step(tbl[i]);

    // Reset mid-stream: output clears asynchronously, ptr returns to 0.
    step(mkv(4'hF, 0, 0, 1, 8'hA2, 4'b0010, "pre_rst"));
    rst_n = 1'b0;
    #1;
    check("async_rst down_valid", 32'(down_valid), 32'h0);
    check("async_rst down_data", 32'(down_data), 32'h0);
    check("async_rst down_id", 32'(down_id), 32'h0);
    check("async_rst up_ready", 32'(up_ready), 32'h0);
    up_valid = '0;
    #1;
    rst_n = 1'b1;
    sb.delete();
    exp_valid = 1'b0;
    step(mkv(4'hF, 0, 0, 1, 8'hA2, 4'b0001, "post_rst"));
    step(mkv(4'h0, 0, 0, 1, 8'hA2, 4'b0000, "drain"));
    check("scoreboard empty", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
